// File: rtl/sync_fifo.sv
// Single-clock FIFO with programmable thresholds and occupancy count.
// FWFT selects registered read or first-word-fall-through output.
module sync_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int AFULL  = 12,
   parameter int AEMPTY = 4,
   parameter int FWFT   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             rd_ok;
   logic             wr_ok;
   logic [CW-1:0]    count_nxt;

   assign rd_ok     = rd_en && !empty;
   assign wr_ok     = wr_en && (!full || rd_ok);
   assign count_nxt = count + CW'(wr_ok) - CW'(rd_ok);

   // Storage write; contents survive reset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_ok)
         mem[wr_ptr] <= wr_data;
   end

   // Pointers, occupancy and flags, all registered from next count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok)
            rd_ptr <= rd_ptr + AW'(1);
         count        <= count_nxt;
         empty        <= (count_nxt == '0);
         full         <= (count_nxt == CW'(DEPTH));
         almost_full  <= (count_nxt >= CW'(AFULL));
         almost_empty <= (count_nxt <= CW'(AEMPTY));
         overflow     <= wr_en && !wr_ok;
         underflow    <= rd_en && !rd_ok;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; zero while empty.
      assign rd_valid = !empty;
      assign rd_data  = empty ? '0 : mem[rd_ptr];
   end else begin : g_reg
      // Registered read port: data lands one cycle after accepted read.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
         end else if (rd_ok) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[rd_ptr];
         end else begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule
